sa_output_drain: RTL and testbench

Reads the result rows that the systolic controller has written into the output-activation memory and transmits them to the host side as a valid/ready stream. Sits between the output memory read port and the off-array interface. Started after the array controller reports done. Absorbs the 1-cycle synchronous-read latency of the memory with a small credit-checked FIFO, so backpressure never drops or duplicates a row.

---
 rtl/sa_pkg.sv | 18 +
 rtl/sa_sync_fifo.sv | 80 ++++++++
 rtl/sa_output_drain.sv | 168 ++++++++++++++++
 tb/tb_sa_output_drain.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sa_pkg
//  Description : Shared types for the systolic-array blocks. Holds the state
//                encoding of the output drain FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

    // Output drain FSM states.
    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_READ = 2'd1,
        DRAIN_WAIT = 2'd2
    } drain_state_e;

endpackage : sa_pkg
`default_nettype wire

// File: rtl/sa_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sa_sync_fifo
//  Description : Single-clock show-ahead FIFO. The head entry is visible on
//                o_data_out whenever o_empty is low; a pop advances it.
//                A push while full is dropped; callers guarantee it never
//                happens through their own flow control.
//  Ports       : clk, rst (async, active high)
//                i_push / i_data_in  - write side
//                i_pop               - consume head entry
//                o_data_out          - head entry
//                o_empty, o_full, o_count - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module sa_sync_fifo #(
    parameter  int WIDTH = 128,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data_in,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_count    = r_count;
    assign o_data_out = r_mem[r_rd_ptr];

    assign w_do_pop   = i_pop  && !o_empty;
    assign w_do_push  = i_push && !o_full;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage needs no reset; occupancy tracking alone defines validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule : sa_sync_fifo
`default_nettype wire

// File: rtl/sa_output_drain.sv
`default_nettype none
// ============================================================================
//  Module      : sa_output_drain
//  Description : Streams i_length rows out of the output-activation memory as
//                a valid/ready stream. Reads are only issued while the skid
//                FIFO has room for every word already in flight, so the
//                1-cycle read latency never overflows under backpressure.
//  Ports       : clk, rst (async, active high)
//                i_start, i_length          - drain request
//                r_output_cenb/wenb/addr    - memory read port controls
//                r_output_data              - memory read data (1-cycle latency)
//                o_valid, o_data, o_last, i_ready - output stream
//                o_busy, o_done             - status (o_done sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module sa_output_drain
    import sa_pkg::*;
#(
    parameter  int OUTPUT_WIDTH  = 128,
    parameter  int OUTPUT_HEIGHT = 16,
    parameter  int FIFO_DEPTH    = 4,
    localparam int ADDR_W        = $clog2(OUTPUT_HEIGHT),
    localparam int LEN_W         = $clog2(OUTPUT_HEIGHT) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [LEN_W-1:0]        i_length,
    output logic                    r_output_cenb,
    output logic                    r_output_wenb,
    output logic [ADDR_W-1:0]       r_output_addr,
    input  logic [OUTPUT_WIDTH-1:0] r_output_data,
    output logic                    o_valid,
    output logic [OUTPUT_WIDTH-1:0] o_data,
    output logic                    o_last,
    input  logic                    i_ready,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    // Wide enough for fifo_count (<= FIFO_DEPTH) plus inflight (<= 2).
    localparam int CRW   = $clog2(FIFO_DEPTH + 3);

    drain_state_e      r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issue_cnt;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic              r_rd_pend;
    logic              r_busy;
    logic              r_done;

    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [1:0]        w_inflight;
    logic [CRW-1:0]    w_used;
    logic              w_credit_ok;
    logic              w_hs;
    logic              w_more;

    // A read is in flight from the cycle its cenb is low until the cycle
    // after, when its data is pushed.
    assign w_inflight  = {1'b0, !r_output_cenb} + {1'b0, r_rd_pend};
    assign w_used      = CRW'(w_fifo_count) + CRW'(w_inflight);
    // Pops in this cycle are deliberately not credited back.
    assign w_credit_ok = (w_used < CRW'(FIFO_DEPTH));
    assign w_more      = (r_issue_cnt != r_len);

    assign o_valid = !w_fifo_empty;
    assign w_hs    = o_valid && i_ready;
    assign o_last  = o_valid && (r_beat_cnt == (r_len - LEN_W'(1)));
    assign o_busy  = r_busy;
    assign o_done  = r_done;

    sa_sync_fifo #(
        .WIDTH (OUTPUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_rd_pend),
        .i_pop      (w_hs),
        .i_data_in  (r_output_data),
        .o_data_out (o_data),
        .o_empty    (w_fifo_empty),
        .o_full     (w_fifo_full),
        .o_count    (w_fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= DRAIN_IDLE;
            r_len         <= '0;
            r_issue_cnt   <= '0;
            r_beat_cnt    <= '0;
            r_rd_pend     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_output_cenb <= 1'b1;
            r_output_wenb <= 1'b1;
            r_output_addr <= '0;
        end else begin
            r_output_wenb <= 1'b1;
            r_output_cenb <= 1'b1;
            // Data for a read launched this cycle appears next cycle.
            r_rd_pend     <= !r_output_cenb;

            if (w_hs) begin
                r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end

            case (r_state)
                DRAIN_IDLE: begin
                    if (i_start) begin
                        r_len         <= i_length;
                        r_beat_cnt    <= '0;
                        r_output_addr <= '0;
                        if (i_length == '0) begin
                            r_issue_cnt <= '0;
                            r_done      <= 1'b1;
                        end else begin
                            // FIFO is empty in IDLE, so the first read
                            // launches immediately to hit the 3-cycle latency.
                            r_done        <= 1'b0;
                            r_busy        <= 1'b1;
                            r_output_cenb <= 1'b0;
                            r_issue_cnt   <= LEN_W'(1);
                            r_state       <= (i_length == LEN_W'(1)) ? DRAIN_WAIT
                                                                     : DRAIN_READ;
                        end
                    end
                end

                DRAIN_READ: begin
                    if (w_more && w_credit_ok) begin
                        r_output_cenb <= 1'b0;
                        r_output_addr <= r_issue_cnt[ADDR_W-1:0];
                        r_issue_cnt   <= r_issue_cnt + LEN_W'(1);
                        if ((r_issue_cnt + LEN_W'(1)) == r_len) begin
                            r_state <= DRAIN_WAIT;
                        end
                    end
                end

                DRAIN_WAIT: begin
                    if (w_hs && o_last) begin
                        r_state <= DRAIN_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= DRAIN_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // The credit rule must make an overflowing push impossible.
    a_no_fifo_overflow: assert property (
        @(posedge clk) disable iff (rst) !(r_rd_pend && w_fifo_full)
    );

endmodule : sa_output_drain
`default_nettype wire

// File: tb/tb_sa_output_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sa_output_drain
//  Description : Scoreboard bench for sa_output_drain with a synchronous-read
//                memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_output_drain;

    localparam int W  = 128;
    localparam int H  = 16;
    localparam int D  = 4;
    localparam int AW = 4;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [LW-1:0] i_length = '0;
    logic          cenb;
    logic          wenb;
    logic [AW-1:0] addr;
    logic [W-1:0]  rdata = '0;
    logic          o_valid;
    logic [W-1:0]  o_data;
    logic          o_last;
    logic          i_ready = 1'b1;
    logic          o_busy;
    logic          o_done;

    logic [W-1:0]  mem [H];
    logic [W-1:0]  exp_q [$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!cenb) rdata <= mem[addr];
    end

    sa_output_drain #(
        .OUTPUT_WIDTH  (W),
        .OUTPUT_HEIGHT (H),
        .FIFO_DEPTH    (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_length      (i_length),
        .r_output_cenb (cenb),
        .r_output_wenb (wenb),
        .r_output_addr (addr),
        .r_output_data (rdata),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_last        (o_last),
        .i_ready       (i_ready),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    // Row k = 3k+1, with a tag in the top bits to tell drains apart.
    task automatic fill_mem(input int tag);
        for (int k = 0; k < H; k++) begin
            mem[k] = (W'(tag) << 96) | W'(3 * k + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Reset held from time zero.
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk_cnt++; if ({cenb, wenb, addr} !== {1'b1, 1'b1, 4'd0}) $display("FAIL rst_mem_port: got cenb=%0b wenb=%0b addr=%0d want 1 1 0", cenb, wenb, addr); else pass_cnt++;
        chk_cnt++; if ({o_valid, o_last, o_busy, o_done} !== 4'b0000) $display("FAIL rst_status: got v/l/b/d=%b want 0000", {o_valid, o_last, o_busy, o_done}); else pass_cnt++;
        rst = 1'b0;
        // Mid-drain reset with the stream stalled.
        fill_mem(5);
        i_ready = 1'b0;
        @(posedge clk); #1; i_start = 1'b1; i_length = LW'(8);
        @(posedge clk); #1; i_start = 1'b0;
        idle(4);
        @(negedge clk);
        chk_cnt++; if ({o_valid, o_busy} !== 2'b11) $display("FAIL rst_pre_active: got valid/busy=%b want 11", {o_valid, o_busy}); else pass_cnt++;
        #2; rst = 1'b1; #1;
        chk_cnt++; if ({cenb, wenb, addr} !== {1'b1, 1'b1, 4'd0}) $display("FAIL rst_async_mem: got cenb=%0b wenb=%0b addr=%0d want 1 1 0", cenb, wenb, addr); else pass_cnt++;
        chk_cnt++; if ({o_valid, o_last, o_busy, o_done} !== 4'b0000) $display("FAIL rst_async_status: got v/l/b/d=%b want 0000", {o_valid, o_last, o_busy, o_done}); else pass_cnt++;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk_cnt++; if ({cenb, o_valid, o_busy, o_done} !== 4'b1000) $display("FAIL rst_hold: got cenb/v/b/d=%b want 1000", {cenb, o_valid, o_busy, o_done}); else pass_cnt++;
        rst = 1'b0;
        i_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_zero_length();
        int lows = 0, vals = 0;
        @(posedge clk); #1; i_start = 1'b1; i_length = '0;
        @(negedge clk);
        chk_cnt++; if (o_done !== 1'b0) $display("FAIL zero_done_c0: got %0b want 0", o_done); else pass_cnt++;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1; i_start = 1'b0;
            @(negedge clk);
            if (!cenb) lows++;
            if (o_valid) vals++;
            if (c == 1) begin
                chk_cnt++; if ({o_done, o_busy} !== 2'b10) $display("FAIL zero_done_c1: got done/busy=%b want 10", {o_done, o_busy}); else pass_cnt++;
            end
        end
        chk_cnt++; if (lows !== 0) $display("FAIL zero_cenb: got %0d low cycles want 0", lows); else pass_cnt++;
        chk_cnt++; if (vals !== 0) $display("FAIL zero_valid: got %0d valid cycles want 0", vals); else pass_cnt++;
    endtask

    task automatic test_basic();
        int lows = 0, beats = 0, exp_addr = 0;
        logic [W-1:0] e;
        fill_mem(0);
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(W'(3 * k + 1));
        i_ready = 1'b1;
        @(posedge clk); #1; i_start = 1'b1; i_length = LW'(4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!cenb) begin
                lows++;
                chk_cnt++; if (int'(addr) !== exp_addr) $display("FAIL basic_addr: got %0d want %0d", addr, exp_addr); else pass_cnt++;
                exp_addr++;
            end
            if (o_valid && i_ready) begin
                chk_cnt++; if (c !== 3 + beats) $display("FAIL basic_beat_cycle: got cycle %0d want %0d", c, 3 + beats); else pass_cnt++;
                if (exp_q.size() == 0) begin
                    chk_cnt++; $display("FAIL basic_extra_beat: got data %0h want no beat", o_data);
                end else begin
                    e = exp_q.pop_front();
                    chk_cnt++; if (o_data !== e) $display("FAIL basic_data: got %0h want %0h", o_data, e); else pass_cnt++;
                    chk_cnt++; if (o_last !== (beats == 3)) $display("FAIL basic_last: got %0b want %0b", o_last, beats == 3); else pass_cnt++;
                end
                beats++;
            end
            if (c == 6) begin
                chk_cnt++; if (o_done !== 1'b0) $display("FAIL basic_done_c6: got %0b want 0", o_done); else pass_cnt++;
            end
            if (c == 7) begin
                chk_cnt++; if ({o_done, o_busy} !== 2'b10) $display("FAIL basic_done_c7: got done/busy=%b want 10", {o_done, o_busy}); else pass_cnt++;
            end
            @(posedge clk); #1; i_start = 1'b0;
        end
        chk_cnt++; if (lows !== 4) $display("FAIL basic_cenb_count: got %0d want 4", lows); else pass_cnt++;
        chk_cnt++; if (beats !== 4) $display("FAIL basic_beat_count: got %0d want 4", beats); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int issued = 0, popped = 0, bad_out = 0, bad_stall = 0, c = 0;
        logic         prev_stall = 1'b0;
        logic [W-1:0] prev_data = '0;
        logic [W-1:0] e;
        fill_mem(8'hA5);
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(mem[k]);
        i_ready = 1'b1;
        @(posedge clk); #1; i_start = 1'b1; i_length = LW'(8);
        while (c < 300 && !(o_done && popped == 8)) begin
            @(negedge clk);
            if (!cenb) issued++;
            // Issued minus popped is FIFO occupancy plus reads in flight.
            if (issued - popped > D) bad_out++;
            if (prev_stall && (!o_valid || o_data !== prev_data)) bad_stall++;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++; $display("FAIL bp_extra_beat: got data %0h want no beat", o_data);
                end else begin
                    e = exp_q.pop_front();
                    chk_cnt++; if (o_data !== e) $display("FAIL bp_data: got %0h want %0h", o_data, e); else pass_cnt++;
                    chk_cnt++; if (o_last !== (popped == 7)) $display("FAIL bp_last: got %0b want %0b", o_last, popped == 7); else pass_cnt++;
                end
                popped++;
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            @(posedge clk); #1;
            i_start = 1'b0;
            c++;
            i_ready = (c >= 4 && c < 14) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        i_ready = 1'b1;
        chk_cnt++; if (c >= 300) $display("FAIL bp_timeout: got popped=%0d done=%0b want 8 and 1", popped, o_done); else pass_cnt++;
        chk_cnt++; if (bad_out !== 0) $display("FAIL bp_outstanding: got %0d cycles above %0d want 0", bad_out, D); else pass_cnt++;
        chk_cnt++; if (bad_stall !== 0) $display("FAIL bp_stall_stable: got %0d unstable cycles want 0", bad_stall); else pass_cnt++;
        chk_cnt++; if (issued !== 8) $display("FAIL bp_reads: got %0d want 8", issued); else pass_cnt++;
    endtask

    task automatic test_full_memory();
        int lows = 0, beats = 0, exp_addr = 0, bad_addr = 0, bad_cyc = 0, last_addr = -1;
        logic [W-1:0] e;
        fill_mem(8'h3C);
        exp_q.delete();
        for (int k = 0; k < H; k++) exp_q.push_back(mem[k]);
        i_ready = 1'b1;
        @(posedge clk); #1; i_start = 1'b1; i_length = LW'(H);
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            if (!cenb) begin
                lows++;
                if (int'(addr) != exp_addr) bad_addr++;
                last_addr = int'(addr);
                exp_addr++;
            end
            if (o_valid && i_ready) begin
                if (c != 3 + beats) bad_cyc++;
                if (exp_q.size() == 0) begin
                    chk_cnt++; $display("FAIL full_extra_beat: got data %0h want no beat", o_data);
                end else begin
                    e = exp_q.pop_front();
                    chk_cnt++; if (o_data !== e) $display("FAIL full_data: got %0h want %0h", o_data, e); else pass_cnt++;
                    chk_cnt++; if (o_last !== (beats == H - 1)) $display("FAIL full_last: got %0b want %0b", o_last, beats == H - 1); else pass_cnt++;
                end
                beats++;
            end
            @(posedge clk); #1;
            // A second start while busy must be ignored.
            i_start  = (c == 5);
            i_length = (c == 5) ? LW'(3) : LW'(H);
        end
        i_start = 1'b0;
        chk_cnt++; if (bad_addr !== 0) $display("FAIL full_addr_seq: got %0d out-of-order addresses want 0", bad_addr); else pass_cnt++;
        chk_cnt++; if (lows !== H) $display("FAIL full_cenb_count: got %0d want %0d", lows, H); else pass_cnt++;
        chk_cnt++; if (last_addr !== H - 1) $display("FAIL full_last_addr: got %0d want %0d", last_addr, H - 1); else pass_cnt++;
        chk_cnt++; if (beats !== H) $display("FAIL full_beat_count: got %0d want %0d", beats, H); else pass_cnt++;
        chk_cnt++; if (bad_cyc !== 0) $display("FAIL full_throughput: got %0d bubbled beats want 0", bad_cyc); else pass_cnt++;
        chk_cnt++; if ({o_done, o_busy} !== 2'b10) $display("FAIL full_done: got done/busy=%b want 10", {o_done, o_busy}); else pass_cnt++;
    endtask

    task automatic test_abort_restart();
        int popped = 0, c = 0, bad_done = 0;
        logic exp_done = 1'b0;
        logic [W-1:0] e;
        fill_mem(8'h11);
        i_ready = 1'b1;
        @(posedge clk); #1; i_start = 1'b1; i_length = LW'(8);
        while (c < 50 && popped < 3) begin
            @(negedge clk);
            if (o_valid && i_ready) popped++;
            @(posedge clk); #1; i_start = 1'b0;
            c++;
        end
        chk_cnt++; if (popped !== 3) $display("FAIL abort_pre_beats: got %0d want 3", popped); else pass_cnt++;
        #2; rst = 1'b1; #1;
        chk_cnt++; if ({o_valid, o_busy, o_done} !== 3'b000) $display("FAIL abort_rst_status: got v/b/d=%b want 000", {o_valid, o_busy, o_done}); else pass_cnt++;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        // New contents expose any stale row that survived the abort.
        fill_mem(8'h77);
        exp_q.delete();
        exp_q.push_back(mem[0]);
        exp_q.push_back(mem[1]);
        popped = 0;
        c = 0;
        @(posedge clk); #1; i_start = 1'b1; i_length = LW'(2);
        while (c < 40 && !(exp_done && o_done)) begin
            @(negedge clk);
            if (o_done !== exp_done) bad_done++;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++; $display("FAIL abort_extra_beat: got data %0h want no beat", o_data);
                end else begin
                    e = exp_q.pop_front();
                    chk_cnt++; if (o_data !== e) $display("FAIL abort_data: got %0h want %0h", o_data, e); else pass_cnt++;
                    chk_cnt++; if (o_last !== (popped == 1)) $display("FAIL abort_last: got %0b want %0b", o_last, popped == 1); else pass_cnt++;
                end
                popped++;
                if (popped == 2) exp_done = 1'b1;
            end
            @(posedge clk); #1; i_start = 1'b0;
            c++;
        end
        chk_cnt++; if (c >= 40) $display("FAIL abort_timeout: got popped=%0d done=%0b want 2 and 1", popped, o_done); else pass_cnt++;
        chk_cnt++; if (bad_done !== 0) $display("FAIL abort_done_timing: got %0d wrong cycles want 0", bad_done); else pass_cnt++;
        chk_cnt++; if (popped !== 2) $display("FAIL abort_beat_count: got %0d want 2", popped); else pass_cnt++;
    endtask

    initial begin
        fill_mem(0);
        test_reset();
        test_zero_length();
        idle(2);
        test_basic();
        idle(2);
        test_backpressure();
        idle(2);
        test_full_memory();
        idle(2);
        test_abort_restart();
        idle(2);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_sa_output_drain
`default_nettype wire
